// File: rtl/wb_sram_bridge_pl.sv
// wb_sram_bridge_pl: Wishbone slave to byte-enable synchronous SRAM bridge with range check and abort handling
module wb_sram_bridge_pl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SRAM_AW = 10,
  parameter int READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic [DATA_WIDTH-1:0]   wb_dat_w,
  output logic [DATA_WIDTH-1:0]   wb_dat_r,
  output logic                    wb_ack,
  output logic                    wb_err,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic                    sram_read_en,
  output logic                    sram_write_en,
  output logic [DATA_WIDTH/8-1:0] sram_byte_en,
  output logic [DATA_WIDTH-1:0]   sram_write_data,
  input  logic [DATA_WIDTH-1:0]   sram_read_data
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] rel;
  logic req, in_range, rd, idle_req, gate, done, ack_d, err_d;
  assign req = wb_cyc & wb_stb;
  assign rel = wb_adr - BASE_ADDR;
  assign in_range = (rel >> (OFF + SRAM_AW)) == '0;
  assign rd = ~wb_we & |wb_sel;
  assign idle_req = (state == IDLE) & req;
  assign done = (state == RD_WAIT) & wb_cyc & (cnt == 3'd0);
  // state and latency counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= 3'd0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
    end
  end
  // next state: reads park in RD_WAIT, everything else answers straight from RESP
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      IDLE: if (req) begin
        state_d = (in_range & rd) ? RD_WAIT : RESP;
        cnt_d = 3'(READ_LATENCY - 1);
      end
      RD_WAIT: begin
        state_d = !wb_cyc ? IDLE : (cnt == 3'd0) ? RESP : RD_WAIT;
        cnt_d = cnt - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // SRAM strobes follow the bus combinationally while idle; next-cycle response flags
  always_comb begin
    gate = rstn & idle_req & in_range;
    sram_addr = wb_adr[OFF +: SRAM_AW];
    sram_byte_en = wb_sel;
    sram_write_data = wb_dat_w;
    sram_write_en = gate & wb_we & |wb_sel;
    sram_read_en = gate & rd;
    ack_d = (idle_req & in_range & ~rd) | done;
    err_d = idle_req & ~in_range;
  end
  // registered Wishbone response; read data only moves on a completed read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      wb_dat_r <= '0;
    end else begin
      wb_ack <= ack_d;
      wb_err <= err_d;
      if (done) wb_dat_r <= sram_read_data;
    end
  end
endmodule

// File: doc/wb_sram_bridge_pl.md
Name: wb_sram_bridge_pl

Overview:
Parametrised Wishbone-slave to byte-enable SRAM bridge.
- Supports configurable data, address and SRAM depth widths.
- Supports configurable SRAM read latency.
- Range-checks addresses and answers out-of-range accesses with ERR.
- Handles zero-SEL accesses and aborted cycles.
- Sits between a Wishbone interconnect slave port and a synchronous single-port SRAM macro with byte write enables.
- All Wishbone response outputs are registered.

Parameters:
- DATA_WIDTH, 32, Wishbone/SRAM data width in bits; multiple of 8, at least 8.
- ADDR_WIDTH, 32, Wishbone byte-address width.
- SRAM_AW, 10, SRAM word-address width; depth = 2**SRAM_AW words.
- READ_LATENCY, 1, SRAM clocks from read_en to valid read_data; 1..7.
- BASE_ADDR, 0, byte address of SRAM word 0; aligned to the SRAM size.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- wb_cyc  in  1  Wishbone cycle
- wb_stb  in  1  Wishbone strobe
- wb_we  in  1  write enable
- wb_sel  in  DATA_WIDTH/8  byte selects
- wb_adr  in  ADDR_WIDTH  byte address
- wb_dat_w  in  DATA_WIDTH  write data
- wb_dat_r  out  DATA_WIDTH  read data, registered
- wb_ack  out  1  acknowledge, registered
- wb_err  out  1  error, registered
- sram_addr  out  SRAM_AW  word address
- sram_read_en  out  1  read strobe
- sram_write_en  out  1  write strobe
- sram_byte_en  out  DATA_WIDTH/8  byte enables
- sram_write_data  out  DATA_WIDTH  write data
- sram_read_data  in  DATA_WIDTH  read data

Behaviour:
- Reset: asynchronous on rstn low.
  - State returns to IDLE; latency counter clears.
  - wb_ack, wb_err, sram_read_en and sram_write_en are 0; wb_dat_r is 0.
  - Reset mid-read discards the pending data; no ACK is issued after reset release.
- Request: req = wb_cyc & wb_stb. It is accepted only in IDLE.
- Word address: wb_adr[log2(DATA_WIDTH/8) +: SRAM_AW].
- Range check: in_range is true when (wb_adr − BASE_ADDR) < 2**SRAM_AW * DATA_WIDTH/8, compared at full ADDR_WIDTH.
- SRAM outputs are combinational from the Wishbone inputs, gated by state==IDLE & req & in_range.
  - sram_addr = word address.
  - sram_byte_en = wb_sel.
  - sram_write_data = wb_dat_w.
  - sram_write_en = gate & wb_we & |wb_sel.
  - sram_read_en = gate & ~wb_we & |wb_sel.
- States: IDLE, RD_WAIT, RESP.
  - IDLE, req accepted in cycle T:
    - out of range: go to RESP, wb_err=1 in T+1; no SRAM strobe.
    - write, or sel==0: go to RESP, wb_ack=1 in T+1.
    - read with sel!=0: load counter = READ_LATENCY−1, go to RD_WAIT.
  - RD_WAIT: decrement counter each cycle.
    - At counter==0 (cycle T+READ_LATENCY), register sram_read_data into wb_dat_r, then go to RESP with wb_ack=1 in cycle T+READ_LATENCY+1.
    - If wb_cyc is low in any RD_WAIT cycle: abort to IDLE, no ACK, wb_dat_r unchanged.
  - RESP: wb_ack/wb_err high for exactly one cycle, then IDLE.
    - A new request is accepted earliest in the cycle after RESP (back-to-back throughput: one access per 2 cycles for writes).
    - wb_stb held high during the RESP cycle is not a new request.
- wb_dat_r holds its last read value. It is unchanged by writes, errors and zero-SEL accesses.
- wb_ack and wb_err are never high together.
- sram_read_en and sram_write_en are mutually exclusive and each lasts at most one cycle per access.
- Latency summary: write / error / zero-SEL ack = 1 cycle; read ack = READ_LATENCY+1 cycles.

Test Plan:
- Reset: rstn=0 asynchronously mid-RD_WAIT (READ_LATENCY=3) -> wb_ack, wb_err and strobes drop immediately; no ACK after release; next read succeeds.
- Write then read (DATA_WIDTH=32, READ_LATENCY=2):
  - Write 0xDEADBEEF, sel=4'hF, adr=0x10 -> sram_write_en one cycle with sram_addr=4; wb_ack at T+1.
  - Read adr=0x10 -> sram_read_en at T; wb_ack at T+3 with wb_dat_r=0xDEADBEEF.
- Byte-lane write: sel=4'b0100, dat=0x00AA0000, SRAM preset 0x11223344 -> sram_byte_en=4'b0100; readback 0x11AA3344.
- Out of range (SRAM_AW=10, BASE_ADDR=0): adr=0x1000 -> no SRAM strobe; wb_err=1 for one cycle at T+1; wb_ack=0.
- Zero SEL: read with sel=0 -> no strobe; wb_ack at T+1; wb_dat_r unchanged.
- Abort: read issued (READ_LATENCY=4), then wb_cyc=0 at T+2 -> no ACK; FSM in IDLE at T+3; a following write is acked normally.
